// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : RV32M multiply/divide unit; single-cycle multiply, 32-step
//               restoring divide, start/done handshake with the execute stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            clear_i,
    input  logic [2:0]      ctrl_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    output logic [XLEN-1:0] result_o,
    output logic            done_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   dvd_q, dvd_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic              isrem_q, isrem_d;

    logic              w_accept;
    logic [XLEN:0]     w_mul_a, w_mul_b;
    logic [63:0]       w_ext_a, w_ext_b, w_prod;
    logic              w_signed_div, w_div_zero, w_div_ovf;
    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_abs1, w_abs2;
    logic [XLEN+1:0]   w_rem_sh;
    logic [XLEN:0]     w_diff, w_rem_nx;
    logic              w_ge;
    logic [XLEN-1:0]   w_quo_nx, w_q_fin, w_r_fin;

    assign w_accept = start_i && !clear_i && (state_q == S_IDLE || state_q == S_DONE);

    // 33-bit extension picks signedness; the low 64 bits of the product are exact.
    assign w_mul_a = {(ctrl_i == 3'd1 || ctrl_i == 3'd2) & src1_i[XLEN-1], src1_i};
    assign w_mul_b = {(ctrl_i == 3'd1) & src2_i[XLEN-1], src2_i};
    assign w_ext_a = {{(64-XLEN-1){w_mul_a[XLEN]}}, w_mul_a};
    assign w_ext_b = {{(64-XLEN-1){w_mul_b[XLEN]}}, w_mul_b};
    assign w_prod  = w_ext_a * w_ext_b;

    assign w_signed_div = !ctrl_i[0];
    assign w_div_zero   = (src2_i == '0);
    assign w_div_ovf    = w_signed_div && (src1_i == {1'b1, {(XLEN-1){1'b0}}})
                          && (src2_i == {XLEN{1'b1}});
    assign w_a_neg      = w_signed_div & src1_i[XLEN-1];
    assign w_b_neg      = w_signed_div & src2_i[XLEN-1];
    assign w_abs1       = w_a_neg ? -src1_i : src1_i;
    assign w_abs2       = w_b_neg ? -src2_i : src2_i;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    assign w_rem_sh = {rem_q, dvd_q[XLEN-1]};
    assign w_ge     = (w_rem_sh >= {2'b00, dvs_q});
    assign w_diff   = w_rem_sh[XLEN:0] - {1'b0, dvs_q};
    assign w_rem_nx = w_ge ? w_diff : w_rem_sh[XLEN:0];
    assign w_quo_nx = {quo_q[XLEN-2:0], w_ge};
    assign w_q_fin  = qneg_q ? -w_quo_nx : w_quo_nx;
    assign w_r_fin  = rneg_q ? -w_rem_nx[XLEN-1:0] : w_rem_nx[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        isrem_d  = isrem_q;

        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (w_accept) begin
                        state_d = S_DONE;
                        if (!ctrl_i[2]) begin
                            result_d = (ctrl_i == 3'd0) ? w_prod[XLEN-1:0]
                                                        : w_prod[2*XLEN-1:XLEN];
                        end else if (w_div_zero) begin
                            result_d = ctrl_i[1] ? src1_i : {XLEN{1'b1}};
                        end else if (w_div_ovf) begin
                            result_d = ctrl_i[1] ? '0 : src1_i;
                        end else begin
                            state_d = S_DIV;
                            dvd_d   = w_abs1;
                            dvs_d   = w_abs2;
                            rem_d   = '0;
                            quo_d   = '0;
                            qneg_d  = w_a_neg ^ w_b_neg;
                            rneg_d  = w_a_neg;
                            isrem_d = ctrl_i[1];
                            cnt_d   = 5'd31;
                        end
                    end
                end
                S_DIV: begin
                    rem_d = w_rem_nx;
                    quo_d = w_quo_nx;
                    dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                    if (cnt_q == 5'd0) begin
                        result_d = isrem_q ? w_r_fin : w_q_fin;
                        state_d  = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            isrem_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            isrem_q  <= isrem_d;
        end
    end

    assign result_o = result_q;
    assign done_o   = (state_q == S_DONE);
    assign busy_o   = (state_q == S_DIV);

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit against an arithmetic model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        clear_i = 1'b0;
    logic [2:0]  ctrl_i = 3'd0;
    logic [31:0] src1_i = 32'd0;
    logic [31:0] src2_i = 32'd0;
    logic [31:0] result_o;
    logic        done_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .clear_i  (clear_i),
        .ctrl_i   (ctrl_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .result_o (result_o),
        .done_o   (done_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, p;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = 0;
        up = 0;
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!op[2]) return 1;
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Model: the latest accepted op, the cycle its done is due, and the visible result.
    int          cyc = 0;
    bit          m_pend = 1'b0;
    int          m_start = 0;
    int          m_done_at = 0;
    logic [31:0] m_pres = 32'd0;
    logic [31:0] m_res = 32'd0;

    always @(posedge clk) begin
        int t;
        t = cyc;
        if (rst) begin
            m_pend = 1'b0;
            m_res  = 32'd0;
        end else if (clear_i) begin
            m_pend = 1'b0;
        end else begin
            if (start_i && (!m_pend || m_done_at <= t)) begin
                m_pend    = 1'b1;
                m_start   = t;
                m_done_at = t + ref_lat(ctrl_i, src1_i, src2_i);
                m_pres    = ref_result(ctrl_i, src1_i, src2_i);
            end
            if (m_pend && m_done_at == t + 1) m_res = m_pres;
        end
        cyc = t + 1;
    end

    always @(negedge clk) begin
        logic e_done, e_busy;
        e_done = m_pend && (m_done_at == cyc);
        e_busy = m_pend && (cyc > m_start) && (cyc < m_done_at);
        checks++;
        if (done_o !== e_done || busy_o !== e_busy || result_o !== m_res) begin
            errors++;
            $display("FAIL cycle_compare cyc=%0d: done=%b busy=%b result=%h, expected done=%b busy=%b result=%h",
                     cyc, done_o, busy_o, result_o, e_done, e_busy, m_res);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom % 16;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int n;
        @(negedge clk);
        start_i = 1'b1; ctrl_i = op; src1_i = a; src2_i = b;
        @(negedge clk);
        start_i = 1'b0; ctrl_i = 3'($urandom); src1_i = $urandom; src2_i = $urandom;
        n = 1;
        while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 32'(n), 32'(exp_lat));
        check({name, "_result"}, result_o, exp_res);
    endtask

    initial begin
        int n, dones;
        logic [31:0] saved;

        #1 rst = 1'b1;
        @(negedge clk);
        check("reset_result", result_o, 32'd0);
        check("reset_flags", {30'd0, done_o, busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("divu",   3'd5, 32'd100,       32'd7,         32'd14,        33);
        run_op("remu",   3'd7, 32'd100,       32'd7,         32'd2,         33);
        run_op("div0",   3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu0",  3'd7, 32'd5,         32'd0,         32'd5,         1);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Abort a divide at T+10.
        run_op("pre_clear", 3'd0, 32'd6, 32'd7, 32'd42, 1);
        @(negedge clk);
        start_i = 1'b1; ctrl_i = 3'd5; src1_i = 32'd1000; src2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        saved = result_o;
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        check("clear_busy", {31'd0, busy_o}, 32'd0);
        check("clear_result", result_o, saved);
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("clear_no_done", 32'(dones), 32'd0);

        // Start during DIV is ignored.
        @(negedge clk);
        start_i = 1'b1; ctrl_i = 3'd4; src1_i = 32'hFFFF_FFF9; src2_i = 32'd2;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        start_i = 1'b1; ctrl_i = 3'd0; src1_i = 32'd3; src2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        n = 5; dones = 0; saved = 32'd0;
        while (n < 45) begin
            if (done_o) begin
                dones++;
                if (dones == 1) saved = 32'(n);
            end
            @(negedge clk);
            n++;
        end
        check("ignore_done_count", 32'(dones), 32'd1);
        check("ignore_latency", saved, 32'd33);
        check("ignore_result", result_o, 32'hFFFF_FFFD);

        // Back-to-back: MUL issued in the DIVU done cycle.
        @(negedge clk);
        start_i = 1'b1; ctrl_i = 3'd5; src1_i = 32'd100; src2_i = 32'd7;
        @(negedge clk);
        start_i = 1'b0;
        n = 1;
        while (!done_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_div_latency", 32'(n), 32'd33);
        start_i = 1'b1; ctrl_i = 3'd0; src1_i = 32'd3; src2_i = 32'd4;
        @(negedge clk);
        start_i = 1'b0;
        check("b2b_mul_done", {31'd0, done_o}, 32'd1);
        check("b2b_mul_result", result_o, 32'd12);

        // Asynchronous reset mid-divide.
        @(negedge clk);
        start_i = 1'b1; ctrl_i = 3'd7; src1_i = 32'd99; src2_i = 32'd10;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_result", result_o, 32'd0);
        check("async_rst_flags", {30'd0, done_o, busy_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic, including starts while busy and occasional aborts.
        repeat (4000) begin
            @(negedge clk);
            start_i = ($urandom % 3 == 0);
            clear_i = ($urandom % 50 == 0);
            ctrl_i  = 3'($urandom);
            src1_i  = pick();
            src2_i  = pick();
        end
        @(negedge clk);
        start_i = 1'b0;
        clear_i = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
